// File: rtl/filter_mem_banked.sv
// filter_mem_banked: DEPTH x DATA_W filter row store with one write port and
// NUM_RD independent read ports, all using valid/ready handshakes.
// Each row has a valid bit. A read of an unwritten row stalls until that row
// is written. A clear pulse invalidates every row between layers.
// Optional feature: define FILTER_MEM_BYPASS_EN to forward same-cycle write
// data to reads of the row being written.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   clear            one-cycle pulse that invalidates all rows
//   wr_valid/ready   write handshake (wr_ready = !clear)
//   wr_addr/data     write row and data
//   rd_req_valid     per-port read request
//   rd_req_ready     per-port request accept (combinational)
//   rd_req_addr      per-port row, port p at [p*ADDR_W +: ADDR_W]
//   rd_data_valid    per-port response valid
//   rd_data_ready    per-port response accept
//   rd_data          per-port response, port p at [p*DATA_W +: DATA_W]
//   err              sticky out-of-range access flag, cleared only by reset
module filter_mem_banked #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_req_valid,
    output logic [NUM_RD-1:0]          rd_req_ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_req_addr,
    output logic [NUM_RD-1:0]          rd_data_valid,
    input  logic [NUM_RD-1:0]          rd_data_ready,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       err
);

    // Storage and handshake state
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]         row_valid_q, row_valid_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                     err_q, err_d;

    // Write-side decode
    logic wr_fire_c;
    logic wr_in_range_c;

    // Per-port read decode
    logic [ADDR_W-1:0] rd_addr_c [NUM_RD];
    logic [NUM_RD-1:0] rd_in_range_c;
    logic [NUM_RD-1:0] rd_hit_c;
    logic [NUM_RD-1:0] slot_free_c;
    logic [NUM_RD-1:0] req_ready_c;
    logic [NUM_RD-1:0] rd_fire_c;

    // Write accept: a clear cycle blocks writes
    always_comb begin
        wr_fire_c     = wr_valid && !clear;
        wr_in_range_c = 32'(wr_addr) < DEPTH;
    end

    // Per-port request decode and accept
    always_comb begin
        rd_in_range_c = '0;
        rd_hit_c      = '0;
        slot_free_c   = '0;
        req_ready_c   = '0;
        rd_fire_c     = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_addr_c[p]     = rd_req_addr[p*ADDR_W +: ADDR_W];
            rd_in_range_c[p] = 32'(rd_addr_c[p]) < DEPTH;
`ifdef FILTER_MEM_BYPASS_EN
            // Forward an in-range write landing on the requested row
            rd_hit_c[p]      = wr_fire_c && wr_in_range_c && (wr_addr == rd_addr_c[p]);
`else
            rd_hit_c[p]      = 1'b0;
`endif
            // Response slot is free when empty or being drained this cycle
            slot_free_c[p]   = !rd_valid_q[p] || rd_data_ready[p];
            // Out-of-range reads never stall; they answer zero and flag err
            req_ready_c[p]   = slot_free_c[p] &&
                               (!rd_in_range_c[p] || row_valid_q[rd_addr_c[p]] || rd_hit_c[p]);
            rd_fire_c[p]     = rd_req_valid[p] && req_ready_c[p];
        end
    end

    // Next-state for row valid bits, responses and err
    always_comb begin
        row_valid_d = row_valid_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q;

        if (clear) begin
            row_valid_d = '0;
        end else if (wr_fire_c && wr_in_range_c) begin
            row_valid_d[wr_addr] = 1'b1;
        end

        if (wr_fire_c && !wr_in_range_c) begin
            err_d = 1'b1;
        end

        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (rd_fire_c[p]) begin
                // New accept replaces any response drained this cycle
                rd_valid_d[p] = 1'b1;
                if (!rd_in_range_c[p]) begin
                    rd_data_d[p*DATA_W +: DATA_W] = '0;
                    err_d = 1'b1;
                end else if (rd_hit_c[p]) begin
                    rd_data_d[p*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_c[p]];
                end
            end else if (rd_data_ready[p]) begin
                rd_valid_d[p] = 1'b0;
            end
        end
    end

    // Handshake and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid_q <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            row_valid_q <= row_valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    // Data array is intentionally not reset; row_valid gates its use
    always_ff @(posedge clk) begin
        if (wr_fire_c && wr_in_range_c) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign wr_ready      = !clear;
    assign rd_req_ready  = req_ready_c;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign err           = err_q;

endmodule

// File: doc/filter_mem_banked.md
# filter_mem_banked

Clocked, parametrised successor to the filter storage used by the PE array. It holds DEPTH rows of DATA_W-bit filter data behind one write port and NUM_RD independent read ports, each port using valid/ready handshakes. Every row carries a valid bit, so a read of an unwritten row stalls until that row is written. A clear input invalidates all rows between layers. It sits between the filter loader on the NoC side and the PE row consumers.

## Interface
- DATA_W, 40, width of one filter row
- DEPTH, 5, number of rows
- ADDR_W, 3, row address width; must satisfy 2**ADDR_W >= DEPTH
- NUM_RD, 2, number of independent read ports
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous and active-low
- clear  input  1  one-cycle pulse that invalidates all rows
- wr_valid  input  1  write request
- wr_ready  output  1  write accept; equals !clear
- wr_addr  input  ADDR_W  write row
- wr_data  input  DATA_W  write data
- rd_req_valid  input  NUM_RD  per-port read request
- rd_req_ready  output  NUM_RD  per-port request accept
- rd_req_addr  input  NUM_RD*ADDR_W  per-port row; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_data_valid  output  NUM_RD  per-port response valid
- rd_data_ready  input  NUM_RD  per-port response accept
- rd_data  output  NUM_RD*DATA_W  per-port response; port p occupies bits [p*DATA_W +: DATA_W]
- err  output  1  sticky flag set by an out-of-range access; cleared only by reset

## Operation
- Storage: the data array is not reset. row_valid[DEPTH] resets to 0.
- Write: the write is accepted when wr_valid && wr_ready.
  - If wr_addr < DEPTH: data[wr_addr] <= wr_data and row_valid[wr_addr] <= 1.
  - If wr_addr >= DEPTH: the write is dropped and err <= 1.
- Clear: clear=1 sets every row_valid to 0 on the next edge and holds wr_ready low for that cycle, so no write is accepted in a clear cycle.
- Read port p:
  - rd_req_ready[p] = slot_free[p] && (addr >= DEPTH || row_valid[addr]).
  - slot_free[p] = !rd_data_valid[p] || rd_data_ready[p].
- Accepted in-range read: on the next edge, rd_data[p] <= data[addr] and rd_data_valid[p] <= 1.
- Accepted out-of-range read: rd_data[p] <= 0, rd_data_valid[p] <= 1, err <= 1.
- Response hold: rd_data[p] and rd_data_valid[p] hold until rd_data_ready[p]=1. If there is no new accept in the same cycle, rd_data_valid[p] then drops.
- Back-to-back: a response drained in the same cycle as a new accept is replaced. This gives full throughput of one read per port per cycle.
- Ports are independent. Any number of ports may read the same row in the same cycle.
- Write/read same row, same cycle (macro off): the read is accepted against the old row_valid. If the row was already valid, the read returns the old data. If the row was invalid, the read stalls one cycle and then returns the new data.
- Clear and read in the same cycle: a read whose row was valid before the edge is still accepted and returns the pre-clear data.
- Reset mid-operation: all handshake state is discarded immediately and in-flight responses are lost.

## Timing
- Reset values: wr_ready=1 (clear is low), rd_req_ready[p]=0 while the requested row is unwritten, rd_data_valid=0, rd_data=0, err=0.
- Read latency: 1 cycle from request accept to rd_data_valid.
- Write-to-visible latency: 1 cycle, with the macro off.
- Inputs are sampled only at the rising edge. rd_req_ready is combinational from row_valid, the slot state and rd_req_addr.
- Stall: a port with an unwritten row keeps rd_req_ready low indefinitely. The requester holds valid and addr stable while it waits.

## Configuration
- FILTER_MEM_BYPASS_EN defined: write-to-read forwarding is enabled. A read of wr_addr in the same cycle as an accepted in-range write is accepted even if the row is invalid, and returns wr_data on the next cycle.
- FILTER_MEM_BYPASS_EN undefined: the behaviour is as described in Operation, with no forwarding.

## Test plan
- Reset, then write row 2 = 0x12_3456_789A, then read row 2 on port 0: rd_data_valid[0]=1 exactly one cycle after accept, rd_data[0]=0x12_3456_789A.
- Read row 4 on port 1 before it is written: rd_req_ready[1] stays 0 for 10 cycles. Write row 4 = 0xAB; the read is accepted the next cycle and returns 0xAB.
- Ports 0 and 1 read rows 0 and 1 every cycle with rd_data_ready=1: one response per port per cycle, data in order. Then rd_data_ready[0]=0 for 3 cycles: port 0 data holds, port 1 is unaffected.
- Write wr_addr=6 with DEPTH=5: err=1 and no row changes. Read addr 7: returns 0 and err stays 1 until reset.
- Write rows 0-4, pulse clear, then read row 3: the read stalls. wr_ready=0 during the clear cycle. Rewrite row 3 = 0x55; the read returns 0x55.
- Write row 1 = 0x77 and read row 1 in the same cycle on an invalid row: with the macro off, one stall cycle then 0x77; with FILTER_MEM_BYPASS_EN, accepted that cycle and 0x77 returned next cycle.
